// File: rtl/lectura_interruptores_gray.sv
`default_nettype none
// ============================================================================
// Module      : lectura_interruptores_gray
// Description : Input-side front end of the Gray decoder board. Reads WIDTH
//               slide switches carrying a Gray word and prepares a clean,
//               committed word for the Gray-to-binary decoder.
//               - Each switch is synchronised to clk (2-FF).
//               - The whole word is debounced: a new value must hold for
//                 DEBOUNCE_CYCLES consecutive cycles before it is committed.
//               - A one-cycle strobe marks every commit.
//               - An error strobe flags commits that are not a Gray-adjacent
//                 (single-bit) step.
// Ports       : clk        in   1      system clock
//               rst        in   1      asynchronous, active-high reset
//               sw         in   WIDTH  raw switches (asynchronous, bouncing)
//               gray       out  WIDTH  committed Gray word
//               gray_valid out  1      pulse: gray updated this cycle
//               gray_err   out  1      pulse with gray_valid: >1 bit changed
// Revision    : 1.0 - initial release
// ============================================================================
module lectura_interruptores_gray #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    // Derived from DEBOUNCE_CYCLES; not meant to be overridden.
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] gray,
    output logic             gray_valid,
    output logic             gray_err
);

    localparam int               C_POP_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [0:0] ESTABLE  = 1'b0;
    localparam logic [0:0] CONTANDO = 1'b1;

    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_candidate;
    logic [CNT_W-1:0]   r_cnt;
    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [WIDTH-1:0]   r_gray;
    logic               r_gray_valid;
    logic               r_gray_err;

    logic               w_differs;
    logic               w_same_cand;
    logic               w_cnt_done;
    logic               w_load_cand;
    logic               w_cnt_inc;
    logic               w_commit;
    logic [WIDTH-1:0]   w_diff;
    logic [C_POP_W-1:0] w_pop;

    // ------------------------------------------------------------------------
    // Two-flop synchroniser; only r_sync2 is used downstream.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_differs   = (r_sync2 != r_gray);
    assign w_same_cand = (r_sync2 == r_candidate);
    assign w_cnt_done  = (r_cnt == C_CNT_LAST);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ESTABLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ESTABLE: begin
                if (w_differs) begin
                    w_state_next = CONTANDO;
                end
            end
            CONTANDO: begin
                // Back to the committed word (glitch) or commit: both end
                // the count.
                if (!w_differs) begin
                    w_state_next = ESTABLE;
                end else if (w_same_cand && w_cnt_done) begin
                    w_state_next = ESTABLE;
                end
            end
            default: w_state_next = ESTABLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output / datapath control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_load_cand = 1'b0;
        w_cnt_inc   = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ESTABLE: begin
                w_load_cand = w_differs;
            end
            CONTANDO: begin
                if (w_differs) begin
                    if (!w_same_cand) begin
                        // Still bouncing: restart the count on the new value.
                        w_load_cand = 1'b1;
                    end else if (w_cnt_done) begin
                        w_commit = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_load_cand = 1'b0;
            end
        endcase
    end

    // Number of bits that flip on commit; a legal Gray step flips exactly one.
    assign w_diff = r_candidate ^ r_gray;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + C_POP_W'(w_diff[i]);
        end
    end

    // ------------------------------------------------------------------------
    // Candidate, debounce counter and committed outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_candidate  <= '0;
            r_cnt        <= '0;
            r_gray       <= '0;
            r_gray_valid <= 1'b0;
            r_gray_err   <= 1'b0;
        end else begin
            if (w_load_cand) begin
                r_candidate <= r_sync2;
                r_cnt       <= '0;
            end else if (w_cnt_inc) begin
                // Counting stops at C_CNT_LAST via commit, so no wrap occurs.
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_commit) begin
                r_gray <= r_candidate;
            end
            // Strobes are asserted only in the cycle right after a commit.
            r_gray_valid <= w_commit;
            r_gray_err   <= w_commit && (w_pop > C_POP_W'(1));
        end
    end

    assign gray       = r_gray;
    assign gray_valid = r_gray_valid;
    assign gray_err   = r_gray_err;

endmodule
`default_nettype wire

// File: tb/tb_lectura_interruptores_gray.sv
`default_nettype none
// ============================================================================
// Module      : tb_lectura_interruptores_gray
// Description : Self-checking bench for lectura_interruptores_gray with
//               WIDTH=4, DEBOUNCE_CYCLES=4. Expected commits (word, error
//               flag, commit edge) are queued when the switches are driven
//               and matched against each gray_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lectura_interruptores_gray;

    localparam int WIDTH = 4;
    localparam int DEB   = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] gray;
    logic             gray_valid;
    logic             gray_err;

    typedef struct {
        logic [WIDTH-1:0] g;
        logic             e;
        int               at_edge;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    logic prev_valid = 1'b0;

    lectura_interruptores_gray #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .gray      (gray),
        .gray_valid(gray_valid),
        .gray_err  (gray_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Output monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (gray_valid) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_pulse: gray=%b err=%b at edge %0d, nothing expected", gray, gray_err, edge_cnt);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                assert (gray === e.g) else begin
                    errors++;
                    $error("FAIL commit_gray: observed %b expected %b", gray, e.g);
                end
                checks++;
                assert (gray_err === e.e) else begin
                    errors++;
                    $error("FAIL commit_err: observed %b expected %b", gray_err, e.e);
                end
                checks++;
                assert (edge_cnt === e.at_edge) else begin
                    errors++;
                    $error("FAIL commit_edge: observed %0d expected %0d", edge_cnt, e.at_edge);
                end
            end
        end else begin
            checks++;
            assert (gray_err === 1'b0) else begin
                errors++;
                $error("FAIL err_without_valid: observed %b expected 0", gray_err);
            end
        end
        checks++;
        assert (!(prev_valid && gray_valid)) else begin
            errors++;
            $error("FAIL double_pulse: observed two consecutive gray_valid at edge %0d", edge_cnt);
        end
        prev_valid <= gray_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a new switch word; the commit is expected at edge 2+DEB counted
    // from the next clock edge (which is edge_cnt+1).
    task automatic drive_expect(input logic [WIDTH-1:0] v, input logic err);
        sw = v;
        sb.push_back('{g: v, e: err, at_edge: edge_cnt + 1 + 2 + DEB});
    endtask

    task automatic check_outputs(input string tag, input logic [WIDTH-1:0] eg,
                                 input logic ev, input logic ee);
        checks++;
        assert (gray === eg) else begin
            errors++;
            $error("FAIL %s gray: observed %b expected %b", tag, gray, eg);
        end
        checks++;
        assert (gray_valid === ev) else begin
            errors++;
            $error("FAIL %s gray_valid: observed %b expected %b", tag, gray_valid, ev);
        end
        checks++;
        assert (gray_err === ee) else begin
            errors++;
            $error("FAIL %s gray_err: observed %b expected %b", tag, gray_err, ee);
        end
    endtask

    // Wait (bounded) for all queued commits, then idle to catch stray pulses.
    task automatic drain(input string tag, input logic [WIDTH-1:0] eg);
        for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL %s timeout: observed %0d pending commits expected 0", tag, sb.size());
        end
        sb.delete();
        repeat (8) tick();
        checks++;
        assert (gray === eg) else begin
            errors++;
            $error("FAIL %s final_gray: observed %b expected %b", tag, gray, eg);
        end
    endtask

    initial begin
        rst = 1'b1;
        sw  = '0;
        repeat (2) tick();
        check_outputs("reset", 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;

        // 1: idle with all switches off
        for (int i = 0; i < 20; i++) begin
            tick();
            check_outputs("idle", 4'b0000, 1'b0, 1'b0);
        end

        // 2: single-bit step
        drive_expect(4'b0001, 1'b0);
        drain("step_0001", 4'b0001);

        // 3: bouncing between 0011 and 0001, then settle on 0011
        for (int k = 0; k < 10; k++) begin
            sw = (k % 2 == 0) ? 4'b0011 : 4'b0001;
            repeat (2) tick();
        end
        checks++;
        assert (gray === 4'b0001) else begin
            errors++;
            $error("FAIL bounce_hold: observed %b expected %b", gray, 4'b0001);
        end
        drive_expect(4'b0011, 1'b0);
        drain("bounce_settle", 4'b0011);

        // 4: short glitch back to the committed word
        sw = 4'b0111;
        repeat (3) tick();
        sw = 4'b0011;
        drain("glitch", 4'b0011);
        repeat (4) tick();

        // 5: two-bit jump flags an error
        drive_expect(4'b1100, 1'b1);
        drain("jump_1100", 4'b1100);

        // 6a: asynchronous reset clears outputs between clock edges
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_outputs("async_rst", 4'b0000, 1'b0, 1'b0);
        sw = 4'b0000;
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        check_outputs("post_rst", 4'b0000, 1'b0, 1'b0);

        // 6b: reset mid-count discards the candidate
        sw = 4'b1100;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check_outputs("midcount_rst", 4'b0000, 1'b0, 1'b0);
        repeat (2) tick();
        check_outputs("held_rst", 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        drive_expect(4'b1100, 1'b1);
        drain("rst_release", 4'b1100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
